// File: rtl/viterbi_decoder_k3_if.sv
// Serial code-bit input and decoded-bit strobe bundle for viterbi_decoder_k3.
// err_cnt is present only when VDEC_ERRCNT_EN is defined.
interface viterbi_decoder_k3_if;
    logic        in;
    logic        in_valid;
    logic        sync;
    logic        out;
    logic        out_valid;
`ifdef VDEC_ERRCNT_EN
    logic [15:0] err_cnt;

    modport master (output in, in_valid, sync, input out, out_valid, err_cnt);
    modport slave  (input in, in_valid, sync, output out, out_valid, err_cnt);
`else
    modport master (output in, in_valid, sync, input out, out_valid);
    modport slave  (input in, in_valid, sync, output out, out_valid);
`endif
endinterface

// File: rtl/viterbi_decoder_k3.sv
// Hard-decision Viterbi decoder, rate 1/2 K=3 (g0=111, g1=110): 4-state ACS, register-exchange survivors.
// Bit of symbol k strobes on the g1 edge of symbol k+TB_DEPTH-1; no stalls. VDEC_ERRCNT_EN adds err_cnt.
module viterbi_decoder_k3 #(
    parameter int TB_DEPTH = 8,
    parameter int PM_W     = 4
) (
    input  logic                clock,
    input  logic                reset,
    viterbi_decoder_k3_if.slave bus
);
    localparam int              SC_W    = $clog2(TB_DEPTH + 1);
    localparam logic [PM_W-1:0] PM_MAX  = '1;
    localparam logic [PM_W-1:0] PM_INIT = PM_W'(1) << (PM_W - 1);
    localparam logic [SC_W-1:0] SC_FULL = SC_W'(TB_DEPTH);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(TB_DEPTH - 1);

    function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] a, input logic [1:0] bm);
        logic [PM_W:0] s;
        s = {1'b0, a} + {{(PM_W - 1){1'b0}}, bm};
        return s[PM_W] ? PM_MAX : s[PM_W-1:0];
    endfunction

    // n = {b,p} is the next state, q selects the predecessor {p,q}
    function automatic logic [1:0] branch_metric(input logic [1:0] n, input logic q,
                                                 input logic r0, input logic r1);
        logic c0, c1;
        c0 = n[1] ^ n[0] ^ q;
        c1 = n[1] ^ n[0];
        return {1'b0, c0 ^ r0} + {1'b0, c1 ^ r1};
    endfunction

    logic                phase_q, phase_d;
    logic                r0_q, r0_d;
    logic [PM_W-1:0]     pm_q [4];
    logic [PM_W-1:0]     pm_d [4];
    logic [TB_DEPTH-1:0] surv_q [4];
    logic [TB_DEPTH-1:0] surv_d [4];
    logic [SC_W-1:0]     sym_cnt_q, sym_cnt_d;
    logic                out_q, out_d;
    logic                out_valid_q, out_valid_d;

    logic [PM_W-1:0]     acs_pm [4];
    logic [TB_DEPTH-1:0] acs_surv [4];
    logic [PM_W-1:0]     m;
    logic [1:0]          best;

    for (genvar n = 0; n < 4; n++) begin : g_acs
        localparam logic [1:0] N = 2'(n);
        localparam logic       B = N[1];
        localparam logic       P = N[0];
        logic [PM_W-1:0] cand0, cand1;
        logic            sel;

        assign cand0       = sat_add(pm_q[{P, 1'b0}], branch_metric(N, 1'b0, r0_q, bus.in));
        assign cand1       = sat_add(pm_q[{P, 1'b1}], branch_metric(N, 1'b1, r0_q, bus.in));
        assign sel         = cand1 < cand0;
        assign acs_pm[n]   = sel ? cand1 : cand0;
        assign acs_surv[n] = {surv_q[{P, sel}][TB_DEPTH-2:0], B};
    end

    // Strict compare keeps the lowest index on ties
    always_comb begin
        m    = acs_pm[0];
        best = 2'd0;
        for (int i = 1; i < 4; i++) begin
            if (acs_pm[i] < m) begin
                m    = acs_pm[i];
                best = 2'(i);
            end
        end
    end

    always_comb begin
        phase_d     = phase_q;
        r0_d        = r0_q;
        pm_d        = pm_q;
        surv_d      = surv_q;
        sym_cnt_d   = sym_cnt_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        if (bus.sync) begin
            phase_d   = 1'b0;
            r0_d      = 1'b0;
            sym_cnt_d = '0;
            for (int i = 0; i < 4; i++) begin
                pm_d[i]   = (i == 0) ? '0 : PM_INIT;
                surv_d[i] = '0;
            end
        end else if (bus.in_valid) begin
            phase_d = ~phase_q;
            if (!phase_q) begin
                r0_d = bus.in;
            end else begin
                for (int i = 0; i < 4; i++) begin
                    pm_d[i]   = acs_pm[i] - m;
                    surv_d[i] = acs_surv[i];
                end
                sym_cnt_d   = (sym_cnt_q == SC_FULL) ? sym_cnt_q : sym_cnt_q + 1'b1;
                out_d       = acs_surv[best][TB_DEPTH-1];
                out_valid_d = (sym_cnt_q >= SC_LAST);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            phase_q     <= 1'b0;
            r0_q        <= 1'b0;
            sym_cnt_q   <= '0;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                pm_q[i]   <= (i == 0) ? '0 : PM_INIT;
                surv_q[i] <= '0;
            end
        end else begin
            phase_q     <= phase_d;
            r0_q        <= r0_d;
            pm_q        <= pm_d;
            surv_q      <= surv_d;
            sym_cnt_q   <= sym_cnt_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;

`ifdef VDEC_ERRCNT_EN
    // Sum of pre-normalisation minima tracks the best path's total distance
    logic [15:0] err_cnt_q, err_cnt_d;
    logic [16:0] err_sum;

    assign err_sum = {1'b0, err_cnt_q} + 17'(m);

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (!bus.sync && bus.in_valid && phase_q)
            err_cnt_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) err_cnt_q <= '0;
        else        err_cnt_q <= err_cnt_d;
    end

    assign bus.err_cnt = err_cnt_q;
`endif
endmodule

// File: tb/tb_viterbi_decoder_k3.sv
// Scoreboard bench for viterbi_decoder_k3: data is encoded here, and the decoded stream must equal
// the transmitted data delayed by TB_DEPTH-1 symbols (sparse single-bit channel errors are corrected).
module tb_viterbi_decoder_k3;
    localparam int       TB_DEPTH = 8;
    localparam bit [9:0] DATA10   = 10'b1011001110;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    viterbi_decoder_k3_if bus ();
    viterbi_decoder_k3 #(.TB_DEPTH(TB_DEPTH), .PM_W(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int strobes     = 0;
    bit exp_q[$];
    bit run_bits[$];
    int nsym;
    int since_err;
    int err_total;
    bit enc_p, enc_q;
    bit model_out;
    bit mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(negedge clock) begin
        if (reset && bus.out_valid === 1'b1) begin
            strobes++;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_strobe: got out_valid=1 with out=%0b, expected no strobe (t=%0t)",
                         bus.out, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                if (bus.out !== mon_exp) begin
                    miscompares++;
                    $display("FAIL decoded_bit: got %0b, expected %0b (t=%0t)", bus.out, mon_exp, $time);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_bit(input bit b, input int gap);
        bus.in       = b;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.in       = 1'($urandom);
        if (gap > 0) repeat ($urandom_range(1, gap)) tick();
    endtask

    task automatic new_run();
        run_bits.delete();
        nsym      = 0;
        enc_p     = 1'b0;
        enc_q     = 1'b0;
        since_err = 12;
    endtask

    // err[1] flips the g0 bit, err[0] flips the g1 bit
    task automatic send_symbol(input bit b, input logic [1:0] err, input int gap);
        bit c0, c1;
        c0 = b ^ enc_p ^ enc_q;
        c1 = b ^ enc_p;
        drive_bit(c0 ^ err[1], gap);
        run_bits.push_back(b);
        nsym++;
        if (nsym >= TB_DEPTH) begin
            exp_q.push_back(run_bits[nsym - TB_DEPTH]);
            model_out = run_bits[nsym - TB_DEPTH];
        end else begin
            model_out = 1'b0;
        end
        err_total += int'(err[1]) + int'(err[0]);
        enc_q = enc_p;
        enc_p = b;
        drive_bit(c1 ^ err[0], gap);
    endtask

    task automatic send_g0_only(input bit b);
        drive_bit(b ^ enc_p ^ enc_q, 0);
    endtask

    task automatic send_data10(input int gap, input int flip_sym);
        for (int i = 0; i < 10 + TB_DEPTH; i++)
            send_symbol((i < 10) ? DATA10[9 - i] : 1'b0, (i == flip_sym) ? 2'b10 : 2'b00, gap);
    endtask

    task automatic drain();
        repeat (2) tick();
        check("pending_outputs", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out", bus.out, 0);
`ifdef VDEC_ERRCNT_EN
        check("rst_err_cnt", bus.err_cnt, 0);
`endif
        exp_q.delete();
        new_run();
        model_out = 1'b0;
        err_total = 0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic do_sync(input bit with_bit);
        bus.sync     = 1'b1;
        bus.in_valid = with_bit;
        bus.in       = 1'($urandom);
        tick();
        bus.sync     = 1'b0;
        bus.in_valid = 1'b0;
        check("sync_out_held", bus.out, model_out);
        check("sync_out_valid", bus.out_valid, 0);
        new_run();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time %0t reached, expected the run to finish earlier", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int         start, len, gap, mode;
        logic [1:0] err;
        bus.in       = 1'b0;
        bus.in_valid = 1'b0;
        bus.sync     = 1'b0;
        #2;
        do_reset();

        // all-zero stream: first strobe exactly on symbol TB_DEPTH
        start = strobes;
        for (int i = 1; i <= 16; i++) begin
            send_symbol(1'b0, 2'b00, 0);
            @(negedge clock);
            #1;
            if (i == TB_DEPTH - 1) check("strobes_before_first", strobes - start, 0);
            if (i == TB_DEPTH)     check("first_strobe", strobes - start, 1);
        end
        drain();
`ifdef VDEC_ERRCNT_EN
        check("err_cnt_clean", bus.err_cnt, 0);
`endif

        do_sync(1'b0);
        send_data10(0, -1);
        drain();

        do_reset();
        send_data10(0, 2);
        drain();
`ifdef VDEC_ERRCNT_EN
        check("err_cnt_one_error", bus.err_cnt, 1);
`endif

        do_sync(1'b0);
        start = strobes;
        send_data10(3, -1);
        drain();
        check("gap_strobe_count", strobes - start, 10 + TB_DEPTH - TB_DEPTH + 1);

        do_sync(1'b0);
        for (int i = 0; i < 4; i++) send_symbol(1'($urandom), 2'b00, 0);
        send_g0_only(1'b1);
        do_reset();
        send_data10(0, -1);
        drain();

        for (int i = 0; i < 6; i++) send_symbol(1'($urandom), 2'b00, 0);
        drain();
        do_sync(1'b1);
        send_data10(1, -1);
        drain();

        // reset directly after a strobing edge must drop out_valid immediately
        for (int i = 0; i < 10; i++) send_symbol(1'($urandom), 2'b00, 0);
        do_reset();

        for (int run = 0; run < 24; run++) begin
            len  = $urandom_range(5, 40);
            gap  = $urandom_range(0, 3);
            mode = $urandom_range(0, 3);
            for (int s = 0; s < len; s++) begin
                err = 2'b00;
                if (since_err >= 12 && $urandom_range(0, 7) == 0) begin
                    err       = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
                    since_err = 0;
                end else begin
                    since_err++;
                end
                send_symbol(1'($urandom), err, gap);
            end
            if (mode == 3) begin
                do_reset();
            end else begin
                drain();
`ifdef VDEC_ERRCNT_EN
                check("err_cnt_run", bus.err_cnt, err_total);
`endif
                if (mode == 2) send_g0_only(1'($urandom));
                do_sync(mode == 1);
            end
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
